// File: rtl/seg7_decode.sv
// Debounced 7-segment glyph decoder: a pattern must hold STABLE_CYCLES extra edges
// before its hex value is emitted once on a valid/ready output. Macro SEG7_ACTIVE_LOW_EN inverts seg.
module seg7_decode #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       ovf,
  output logic       o_dbg_state
);

  // Handshake: a result transfers on a rising edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, nibble/err stay frozen.

  typedef enum logic {
    ST_WAIT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0] w_seg;
  logic [6:0] r_s_reg;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic       w_changed;
  state_t     r_state;
  state_t     w_state_next;
  logic       w_emit;
  logic       w_hs;
  logic [3:0] w_dec_nibble;
  logic       w_dec_err;
  logic [3:0] r_nibble;
  logic       r_err;
  logic       r_valid;
  logic       r_ovf;

`ifdef SEG7_ACTIVE_LOW_EN
  assign w_seg = ~seg;
`else
  assign w_seg = seg;
`endif

  assign w_changed = (w_seg != r_s_reg);
  assign w_hs      = r_valid && out_ready;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_changed) begin
      w_cnt_next = 8'd0;
    end else if (r_cnt != STABLE_MAX) begin
      w_cnt_next = r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_reg <= 7'd0;
      r_cnt   <= 8'd0;
      r_state <= ST_WAIT;
    end else begin
      r_s_reg <= w_seg;
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  // Emission happens on the very edge the counter reaches its threshold.
  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    case (r_state)
      ST_WAIT: begin
        if (w_cnt_next == STABLE_MAX) begin
          w_emit       = 1'b1;
          w_state_next = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_changed) begin
          w_state_next = ST_WAIT;
        end
      end
      default: w_state_next = ST_WAIT;
    endcase
  end

  always_comb begin
    w_dec_nibble = 4'h0;
    w_dec_err    = 1'b0;
    case (r_s_reg)
      7'h3F: w_dec_nibble = 4'h0;
      7'h06: w_dec_nibble = 4'h1;
      7'h5B: w_dec_nibble = 4'h2;
      7'h4F: w_dec_nibble = 4'h3;
      7'h66: w_dec_nibble = 4'h4;
      7'h6D: w_dec_nibble = 4'h5;
      7'h7D: w_dec_nibble = 4'h6;
      7'h07: w_dec_nibble = 4'h7;
      7'h7F: w_dec_nibble = 4'h8;
      7'h6F: w_dec_nibble = 4'h9;
      7'h77: w_dec_nibble = 4'hA;
      7'h7C: w_dec_nibble = 4'hB;
      7'h39: w_dec_nibble = 4'hC;
      7'h5E: w_dec_nibble = 4'hD;
      7'h79: w_dec_nibble = 4'hE;
      7'h71: w_dec_nibble = 4'hF;
      default: w_dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nibble <= 4'h0;
      r_err    <= 1'b0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_emit && (!r_valid || w_hs)) begin
        r_nibble <= w_dec_nibble;
        r_err    <= w_dec_err;
        r_valid  <= 1'b1;
      end else if (w_emit) begin
        r_ovf <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign nibble      = r_nibble;
  assign err         = r_err;
  assign out_valid   = r_valid;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seg7_decode.sv
// Bench for seg7_decode: directed glyph vectors feed an expected-result queue that a
// negedge monitor drains on every output handshake; timing and flag checks inline.
module tb_seg7_decode;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] nibble;
  logic       err;
  logic       out_valid;
  logic       out_ready;
  logic       ovf;
  logic       o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  seg7_decode #(.STABLE_CYCLES(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg        (seg),
    .nibble     (nibble),
    .err        (err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] phys(input logic [6:0] p);
`ifdef SEG7_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: hold a logical pattern for n rising edges, return 1ns after the last
  task automatic hold(input logic [6:0] p, input int n);
    seg = phys(p);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got err=%0b nibble=%0h expected none", err, nibble);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({err, nibble} !== e) begin
          n_fail++;
          $display("FAIL result: got err=%0b nibble=%0h expected err=%0b nibble=%0h",
                   err, nibble, e[4], e[3:0]);
        end
      end
    end
  end

  logic [6:0] glyphs [16];

  initial begin
    glyphs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    rst_n     = 1'b0;
    seg       = phys(7'h00);
    out_ready = 1'b1;
    #12;
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_nibble", 32'(nibble), 32'(0));
    check("reset_err", 32'(err), 32'(0));
    check("reset_ovf", 32'(ovf), 32'(0));
    check("reset_state", 32'(o_dbg_state), 32'(0));
    #11;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // latency: 5B held 4 edges -> valid on the 4th, gone on the 5th
    exp_q.push_back({1'b0, 4'h2});
    seg = phys(7'h5B);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("latency_valid_edge%0d", i), 32'(out_valid), 32'(i == 4));
    end
    check("latency_nibble", 32'(nibble), 32'(2));
    check("latency_state_locked", 32'(o_dbg_state), 32'(1));
    @(posedge clk);
    #1;
    check("latency_valid_falls", 32'(out_valid), 32'(0));

    // sweep all glyphs
    for (int g = 0; g < 16; g++) begin
      exp_q.push_back({1'b0, 4'(g)});
      hold(glyphs[g], 6);
    end
    check("sweep_valid_idle", 32'(out_valid), 32'(0));

    // glitch to 7F for 2 edges, then back to 4F
    exp_q.push_back({1'b0, 4'h3});
    hold(7'h4F, 6);
    hold(7'h7F, 2);
    exp_q.push_back({1'b0, 4'h3});
    hold(7'h4F, 6);
    check("glitch_ovf_clear", 32'(ovf), 32'(0));

    // overflow: 8 held, 3 dropped
    out_ready = 1'b0;
    exp_q.push_back({1'b0, 4'h8});
    hold(7'h7F, 6);
    check("ovf_not_yet", 32'(ovf), 32'(0));
    hold(7'h4F, 6);
    check("ovf_set", 32'(ovf), 32'(1));
    check("ovf_valid_held", 32'(out_valid), 32'(1));
    check("ovf_nibble_held", 32'(nibble), 32'(8));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovf_valid_falls", 32'(out_valid), 32'(0));
    check("ovf_sticky", 32'(ovf), 32'(1));

    // illegal patterns
    exp_q.push_back({1'b1, 4'h0});
    hold(7'h00, 6);
    exp_q.push_back({1'b1, 4'h0});
    hold(7'h01, 6);

    // async reset with a held result and a count in progress
    out_ready = 1'b0;
    hold(7'h06, 5);
    hold(7'h5B, 2);
    check("pre_reset_valid", 32'(out_valid), 32'(1));
    check("pre_reset_ovf", 32'(ovf), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'(0));
    check("async_nibble", 32'(nibble), 32'(0));
    check("async_err", 32'(err), 32'(0));
    check("async_ovf", 32'(ovf), 32'(0));
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seg       = phys(7'h06);
    exp_q.push_back({1'b0, 4'h1});
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_valid_edge%0d", i), 32'(out_valid), 32'(i == 4));
    end
    hold(7'h06, 3);
    check("post_reset_ovf", 32'(ovf), 32'(0));

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
